fft_twiddle_sequencer: RTL

//  Schedules an in-place radix-2 DIT FFT. It walks every stage/group/butterfly and presents

---
 rtl/fft_twiddle_sequencer.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/fft_twiddle_sequencer.sv
// Radix-2 DIT FFT butterfly scheduler: walks stage/group/k and drives the registered twiddle ROM
// address one cycle ahead of the descriptor. Optional FFT_TWSEQ_STAGE_SYNC_EN adds a stage_ack gate.
module fft_twiddle_sequencer #(
  parameter int LOG2N  = 5,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
`ifdef FFT_TWSEQ_STAGE_SYNC_EN
  input  logic              stage_ack,
`endif
  output logic [ADDR_W-1:0] rom_addr,
  output logic              bfly_valid,
  input  logic              bfly_ready,
  output logic [LOG2N-1:0]  idx_a,
  output logic [LOG2N-1:0]  idx_b,
  output logic [LOG2N-1:0]  stage,
  output logic              bfly_last,
  output logic              busy,
  output logic              done
);

  localparam int N = 1 << LOG2N;

  // Handshake: a descriptor transfers on a rising edge where bfly_valid && bfly_ready.
  // Once raised, bfly_valid and the descriptor fields stay put until that transfer.
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_WAIT_ACK, S_DONE} state_t;

  state_t state_q, state_d;

  logic [LOG2N-1:0]  s_q, g_q, k_q;
  logic [LOG2N-1:0]  nxt_s, nxt_g, nxt_k;
  logic [LOG2N:0]    half_w, grp_w, base_w, idx_a_w, nxt_half_w;
  logic [LOG2N-1:0]  half_m1, grp_m1;
  logic              k_end, g_end, stage_end, final_b;
  logic              accept, advance;
  logic [ADDR_W-1:0] cur_addr, nxt_addr;

  // Geometry of the current stage, derived from the counters
  always_comb begin
    half_w    = (LOG2N+1)'(1) << s_q;
    grp_w     = (LOG2N+1)'(N) >> (s_q + 1'b1);
    half_m1   = LOG2N'(half_w - 1'b1);
    grp_m1    = LOG2N'(grp_w - 1'b1);
    base_w    = (LOG2N+1)'(g_q) << (s_q + 1'b1);
    idx_a_w   = base_w + (LOG2N+1)'(k_q);
    k_end     = (k_q == half_m1);
    g_end     = (g_q == grp_m1);
    stage_end = k_end && g_end;
    final_b   = stage_end && (s_q == LOG2N'(LOG2N - 1));
    cur_addr  = ADDR_W'(half_m1) + ADDR_W'(k_q);
  end

  assign accept  = bfly_valid && bfly_ready;
  assign advance = !abort && (((state_q == S_IDLE) && start) ||
                              ((state_q == S_RUN) && accept));

  // Next descriptor; from IDLE or after the final butterfly the walk restarts at zero
  always_comb begin
    nxt_s = s_q;
    nxt_g = g_q;
    nxt_k = k_q;
    if ((state_q == S_IDLE) || final_b) begin
      nxt_s = '0;
      nxt_g = '0;
      nxt_k = '0;
    end else if (!k_end) begin
      nxt_k = k_q + 1'b1;
    end else if (!g_end) begin
      nxt_k = '0;
      nxt_g = g_q + 1'b1;
    end else begin
      nxt_k = '0;
      nxt_g = '0;
      nxt_s = s_q + 1'b1;
    end
    nxt_half_w = ((LOG2N+1)'(1) << nxt_s) - 1'b1;
    nxt_addr   = ADDR_W'(nxt_half_w) + ADDR_W'(nxt_k);
  end

  // Look ahead on advance so the registered ROM output lines up with the presented descriptor
  assign rom_addr = advance ? nxt_addr : cur_addr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_q <= '0;
      g_q <= '0;
      k_q <= '0;
    end else if (abort || (state_q == S_DONE)) begin
      s_q <= '0;
      g_q <= '0;
      k_q <= '0;
    end else if (advance) begin
      s_q <= nxt_s;
      g_q <= nxt_g;
      k_q <= nxt_k;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (start && !abort) state_d = S_RUN;
      S_RUN: begin
        if (abort)                   state_d = S_IDLE;
        else if (accept && final_b)  state_d = S_DONE;
`ifdef FFT_TWSEQ_STAGE_SYNC_EN
        else if (accept && stage_end) state_d = S_WAIT_ACK;
`endif
      end
      S_WAIT_ACK: begin
`ifdef FFT_TWSEQ_STAGE_SYNC_EN
        if (abort)          state_d = S_IDLE;
        else if (stage_ack) state_d = S_RUN;
`else
        state_d = S_IDLE;
`endif
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    bfly_valid = (state_q == S_RUN);
    busy       = (state_q == S_RUN) || (state_q == S_WAIT_ACK);
    done       = (state_q == S_DONE);
    bfly_last  = (state_q == S_RUN) && stage_end;
    stage      = s_q;
    idx_a      = idx_a_w[LOG2N-1:0];
    idx_b      = busy ? (idx_a_w[LOG2N-1:0] + half_w[LOG2N-1:0]) : '0;
  end

endmodule
